// File: rtl/vrf_port_scheduler_if.sv
// Requester-side bundle of the vector register file scheduler.
// The router ports drive the master side; the scheduler sits on the slave side.
interface vrf_port_scheduler_if #(
   parameter int NUM_REQ        = 4,
   parameter int VRF_ADDR_WIDTH = 10,
   parameter int VRF_DATA_WIDTH = 1024
);
   logic [NUM_REQ-1:0]                rd_req;
   logic [NUM_REQ*VRF_ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_REQ-1:0]                rd_gnt;
   logic [NUM_REQ-1:0]                rd_valid;
   logic [VRF_DATA_WIDTH-1:0]         rd_data;
   logic [NUM_REQ-1:0]                wr_req;
   logic [NUM_REQ*VRF_ADDR_WIDTH-1:0] wr_addr;
   logic [NUM_REQ*VRF_DATA_WIDTH-1:0] wr_data;
   logic [NUM_REQ-1:0]                wr_gnt;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  rd_gnt, rd_valid, rd_data, wr_gnt
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output rd_gnt, rd_valid, rd_data, wr_gnt
   );
endinterface

// File: rtl/vrf_port_scheduler.sv
// Shares the dual-port VRF BRAM between NUM_REQ requesters: port A is the
// write port, port B the read port, each with its own round-robin arbiter.
// A read that hits the address being written in the same cycle is delayed
// one cycle so it always returns the new data; a second back-to-back hit for
// the same reader makes the write wait instead, so nobody starves.
module vrf_port_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int VRF_ADDR_WIDTH = 10,
   parameter int VRF_DATA_WIDTH = 1024,
   parameter int READ_LATENCY   = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   vrf_port_scheduler_if.slave       bus,
   output logic [VRF_ADDR_WIDTH-1:0] bram_a_addr_o,
   output logic [VRF_DATA_WIDTH-1:0] bram_a_din_o,
   output logic                      bram_a_en_o,
   output logic                      bram_a_we_o,
   output logic [VRF_ADDR_WIDTH-1:0] bram_b_addr_o,
   input  logic [VRF_DATA_WIDTH-1:0] bram_b_dout_i,
   output logic                      bram_b_en_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef logic [PTR_W-1:0] ptr_t;

   typedef enum logic {
      RD_NORMAL,
      RD_STALLED
   } rdState_e;

   // Cyclic successor of a requester index; wraps explicitly so that
   // non-power-of-two requester counts never visit unused indices.
   function automatic ptr_t nextPtr(input ptr_t p);
      return (p == ptr_t'(NUM_REQ - 1)) ? '0 : ptr_t'(p + 1'b1);
   endfunction

   // First requesting index found when scanning cyclically from ptr.
   // Returns {found, index}.
   function automatic logic [PTR_W:0] rrSearch(input logic [NUM_REQ-1:0] req,
                                                input ptr_t ptr);
      ptr_t idx;
      ptr_t sel;
      logic found;
      idx   = ptr;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
         idx = nextPtr(idx);
      end
      return {found, sel};
   endfunction

   function automatic logic [NUM_REQ-1:0] oneHot(input ptr_t i);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         oh[k] = (ptr_t'(k) == i);
      end
      return oh;
   endfunction

   ptr_t     wrPtr_q, wrPtr_d;
   ptr_t     rdPtr_q, rdPtr_d;
   ptr_t     stallIdx_q, stallIdx_d;
   rdState_e rdState_q, rdState_d;

   logic [READ_LATENCY-1:0] validPipe_q;
   ptr_t                    idxPipe_q [READ_LATENCY];

   logic [VRF_ADDR_WIDTH-1:0] rdAddrArr [NUM_REQ];
   logic [VRF_ADDR_WIDTH-1:0] wrAddrArr [NUM_REQ];
   logic [VRF_DATA_WIDTH-1:0] wrDataArr [NUM_REQ];

   logic wrFound, rdFound;
   ptr_t wrSel, rdSel;
   logic collide;
   logic wrGrant, rdGrant;

   for (genvar g = 0; g < NUM_REQ; g++) begin : gSlice
      assign rdAddrArr[g] = bus.rd_addr[g*VRF_ADDR_WIDTH +: VRF_ADDR_WIDTH];
      assign wrAddrArr[g] = bus.wr_addr[g*VRF_ADDR_WIDTH +: VRF_ADDR_WIDTH];
      assign wrDataArr[g] = bus.wr_data[g*VRF_DATA_WIDTH +: VRF_DATA_WIDTH];
   end

   // Candidate selection: round-robin per port, with a stalled reader forced back in first.
   always_comb begin
      {wrFound, wrSel} = rrSearch(bus.wr_req, wrPtr_q);
      {rdFound, rdSel} = rrSearch(bus.rd_req, rdPtr_q);
      if (rdState_q == RD_STALLED && bus.rd_req[stallIdx_q]) begin
         rdFound = 1'b1;
         rdSel   = stallIdx_q;
      end
   end

   // Collision resolution, stall bookkeeping and pointer advance.
   always_comb begin
      rdState_d  = RD_NORMAL;
      stallIdx_d = stallIdx_q;
      wrGrant    = wrFound;
      rdGrant    = rdFound;
      collide    = wrFound && rdFound && (rdAddrArr[rdSel] == wrAddrArr[wrSel]);
      if (collide) begin
         case (rdState_q)
            RD_NORMAL: begin
               rdGrant    = 1'b0;
               rdState_d  = RD_STALLED;
               stallIdx_d = rdSel;
            end
            RD_STALLED: begin
               wrGrant = 1'b0;
            end
            default: begin
               rdGrant = 1'b0;
            end
         endcase
      end
      wrPtr_d = wrGrant ? nextPtr(wrSel) : wrPtr_q;
      rdPtr_d = rdGrant ? nextPtr(rdSel) : rdPtr_q;
   end

   // Arbiter pointers and the stall flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         stallIdx_q <= '0;
         rdState_q  <= RD_NORMAL;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         stallIdx_q <= stallIdx_d;
         rdState_q  <= rdState_d;
      end
   end

   // Read-return pipeline tracking which requester owns each in-flight read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validPipe_q <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            idxPipe_q[s] <= '0;
         end
      end else begin
         validPipe_q[0] <= rdGrant;
         idxPipe_q[0]   <= rdSel;
         for (int s = 1; s < READ_LATENCY; s++) begin
            validPipe_q[s] <= validPipe_q[s-1];
            idxPipe_q[s]   <= idxPipe_q[s-1];
         end
      end
   end

   // Grants, BRAM controls and read return; everything is forced quiet while in reset.
   always_comb begin
      bus.wr_gnt    = '0;
      bus.rd_gnt    = '0;
      bus.rd_valid  = '0;
      bus.rd_data   = '0;
      bram_a_addr_o = '0;
      bram_a_din_o  = '0;
      bram_a_en_o   = 1'b0;
      bram_a_we_o   = 1'b0;
      bram_b_addr_o = '0;
      bram_b_en_o   = 1'b0;
      if (rst_n) begin
         if (wrGrant) begin
            bus.wr_gnt    = oneHot(wrSel);
            bram_a_en_o   = 1'b1;
            bram_a_we_o   = 1'b1;
            bram_a_addr_o = wrAddrArr[wrSel];
            bram_a_din_o  = wrDataArr[wrSel];
         end
         if (rdGrant) begin
            bus.rd_gnt    = oneHot(rdSel);
            bram_b_en_o   = 1'b1;
            bram_b_addr_o = rdAddrArr[rdSel];
         end
         if (validPipe_q[READ_LATENCY-1]) begin
            bus.rd_valid = oneHot(idxPipe_q[READ_LATENCY-1]);
         end
         bus.rd_data = bram_b_dout_i;
      end
   end

endmodule

// File: tb/tb_vrf_port_scheduler.sv
// Testbench for vrf_port_scheduler: a behavioural BRAM, a reference model of
// the arbitration/return rules checked every cycle, plus directed scenarios
// with literal expectations.
module tb_vrf_port_scheduler;

   localparam int N   = 4;
   localparam int AW  = 10;
   localparam int DW  = 64;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic bramClear;

   logic [AW-1:0] aAddr, bAddr;
   logic [DW-1:0] aDin, bDout;
   logic          aEn, aWe, bEn;

   int errors = 0;
   int checks = 0;

   vrf_port_scheduler_if #(.NUM_REQ(N), .VRF_ADDR_WIDTH(AW), .VRF_DATA_WIDTH(DW)) bus ();

   vrf_port_scheduler #(
      .NUM_REQ(N), .VRF_ADDR_WIDTH(AW), .VRF_DATA_WIDTH(DW), .READ_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .bram_a_addr_o(aAddr),
      .bram_a_din_o(aDin),
      .bram_a_en_o(aEn),
      .bram_a_we_o(aWe),
      .bram_b_addr_o(bAddr),
      .bram_b_dout_i(bDout),
      .bram_b_en_o(bEn)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Behavioural dual-port BRAM with LAT-cycle registered read on port B.
   logic [DW-1:0] bramMem  [1<<AW];
   logic [DW-1:0] bramPipe [LAT];
   assign bDout = bramPipe[LAT-1];

   always @(posedge clk) begin
      if (bramClear) begin
         for (int a = 0; a < (1<<AW); a++) bramMem[a] <= '0;
         for (int s = 0; s < LAT; s++) bramPipe[s] <= '0;
      end else begin
         if (bEn) bramPipe[0] <= bramMem[bAddr];
         for (int s = 1; s < LAT; s++) bramPipe[s] <= bramPipe[s-1];
         if (aEn && aWe) bramMem[aAddr] <= aDin;
      end
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      int            idx;
      logic [DW-1:0] data;
   } ret_t;

   int            mWrPtr = 0;
   int            mRdPtr = 0;
   int            mStallIdx = 0;
   bit            mStalled = 0;
   int            cyc = 0;
   logic [DW-1:0] mMem [int];
   ret_t          mQ [$];

   function automatic int rrFirst(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (req[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [AW-1:0] sliceA(input logic [N*AW-1:0] v, input int i);
      return v[i*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] sliceD(input logic [N*DW-1:0] v, input int i);
      return v[i*DW +: DW];
   endfunction

   // Compare DUT against the model every cycle, then advance the model by one clock.
   always @(negedge clk) begin : compare
      logic [N-1:0]  eWr, eRd, eVal;
      logic [AW-1:0] wA, rA;
      logic [DW-1:0] eData;
      int            w, r;
      bit            wOk, rOk, coll, valExp;
      ret_t          ent;
      cyc++;
      if (!rst_n) begin
         mWrPtr = 0;
         mRdPtr = 0;
         mStalled = 0;
         mQ.delete();
         checkOutput("rst wr_gnt", bus.wr_gnt, '0);
         checkOutput("rst rd_gnt", bus.rd_gnt, '0);
         checkOutput("rst rd_valid", bus.rd_valid, '0);
         checkOutput("rst rd_data", bus.rd_data, '0);
         checkOutput("rst a_en/we", {aEn, aWe}, '0);
         checkOutput("rst b_en", bEn, '0);
         checkOutput("rst a_addr", aAddr, '0);
         checkOutput("rst a_din", aDin, '0);
         checkOutput("rst b_addr", bAddr, '0);
      end else begin
         w = rrFirst(bus.wr_req, mWrPtr);
         r = (mStalled && bus.rd_req[mStallIdx]) ? mStallIdx : rrFirst(bus.rd_req, mRdPtr);
         wOk = (w >= 0);
         rOk = (r >= 0);
         wA = wOk ? sliceA(bus.wr_addr, w) : '0;
         rA = rOk ? sliceA(bus.rd_addr, r) : '0;
         coll = wOk && rOk && (wA == rA);
         if (coll) begin
            if (mStalled) wOk = 0;
            else rOk = 0;
         end
         eWr = '0;
         eRd = '0;
         eVal = '0;
         if (wOk) eWr[w] = 1'b1;
         if (rOk) eRd[r] = 1'b1;
         valExp = 0;
         eData = '0;
         while (mQ.size() > 0 && mQ[0].due < cyc) void'(mQ.pop_front());
         if (mQ.size() > 0 && mQ[0].due == cyc) begin
            ent = mQ.pop_front();
            eVal[ent.idx] = 1'b1;
            eData = ent.data;
            valExp = 1;
         end
         checkOutput("wr_gnt", bus.wr_gnt, eWr);
         checkOutput("rd_gnt", bus.rd_gnt, eRd);
         checkOutput("rd_valid", bus.rd_valid, eVal);
         checkOutput("a_en", aEn, wOk);
         checkOutput("a_we", aWe, wOk);
         checkOutput("b_en", bEn, rOk);
         if (wOk) begin
            checkOutput("a_addr", aAddr, wA);
            checkOutput("a_din", aDin, sliceD(bus.wr_data, w));
         end
         if (rOk) checkOutput("b_addr", bAddr, rA);
         if (valExp) checkOutput("rd_data", bus.rd_data, eData);
         if (rOk) begin
            ent.due  = cyc + LAT;
            ent.idx  = r;
            ent.data = mMem.exists(int'(rA)) ? mMem[int'(rA)] : '0;
            mQ.push_back(ent);
            mRdPtr = (r + 1) % N;
         end
         if (wOk) begin
            mMem[int'(wA)] = sliceD(bus.wr_data, w);
            mWrPtr = (w + 1) % N;
         end
         mStalled = coll && !rOk;
         if (mStalled) mStallIdx = r;
      end
   end

   // ---------------- stimulus ----------------
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] wreq, input logic [N-1:0] rreq);
      bus.wr_req = wreq;
      bus.rd_req = rreq;
   endtask

   task automatic setWr(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bus.wr_addr[i*AW +: AW] = addr;
      bus.wr_data[i*DW +: DW] = data;
   endtask

   task automatic setRd(input int i, input logic [AW-1:0] addr);
      bus.rd_addr[i*AW +: AW] = addr;
   endtask

   initial begin
      rst_n = 1'b0;
      bramClear = 1'b1;
      bus.wr_addr = '0;
      bus.rd_addr = '0;
      bus.wr_data = '0;
      applyStimulus('0, '0);

      // 1. Reset with random inputs, then idle release.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(N'($urandom), N'($urandom));
         for (int k = 0; k < N; k++) begin
            setWr(k, AW'($urandom), {$urandom, $urandom});
            setRd(k, AW'($urandom));
         end
         #2;
         checkOutput("reset gnts", {bus.wr_gnt, bus.rd_gnt}, '0);
         checkOutput("reset enables", {aEn, aWe, bEn}, '0);
         nextCycle();
      end
      applyStimulus('0, '0);
      bramClear = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         checkOutput("idle enables", {aEn, bEn}, '0);
         nextCycle();
      end

      // 2. Write round-robin over all requesters.
      for (int k = 0; k < N; k++) setWr(k, AW'(10'h100 + k), 64'hD0D0_0000_0000_0000 | 64'(k));
      applyStimulus(4'b1111, 4'b0000);
      for (int k = 0; k < 8; k++) begin
         #2;
         checkOutput("wrRR gnt", bus.wr_gnt, DW'(1 << (k % 4)));
         checkOutput("wrRR addr", aAddr, DW'(10'h100 + (k % 4)));
         checkOutput("wrRR din", aDin, 64'hD0D0_0000_0000_0000 | 64'(k % 4));
         nextCycle();
      end
      applyStimulus('0, '0);

      // Preload 0x05..0x07 through requester 0.
      setWr(0, 10'h005, 64'h5555);
      applyStimulus(4'b0001, 4'b0000);
      nextCycle();
      setWr(0, 10'h006, 64'h6666);
      nextCycle();
      setWr(0, 10'h007, 64'h7777);
      nextCycle();
      applyStimulus('0, '0);

      // 3. Read latency and tagging.
      setRd(2, 10'h005);
      applyStimulus(4'b0000, 4'b0100);
      #2;
      checkOutput("rdLat gnt c0", bus.rd_gnt, 4'b0100);
      checkOutput("rdLat b_addr c0", bAddr, 10'h005);
      nextCycle();
      setRd(0, 10'h006);
      applyStimulus(4'b0000, 4'b0001);
      #2;
      checkOutput("rdLat gnt c1", bus.rd_gnt, 4'b0001);
      nextCycle();
      setRd(1, 10'h007);
      applyStimulus(4'b0000, 4'b0010);
      #2;
      checkOutput("rdLat gnt c2", bus.rd_gnt, 4'b0010);
      checkOutput("rdLat valid c2", bus.rd_valid, 4'b0100);
      checkOutput("rdLat data c2", bus.rd_data, 64'h5555);
      nextCycle();
      applyStimulus('0, '0);
      #2;
      checkOutput("rdLat valid c3", bus.rd_valid, 4'b0001);
      checkOutput("rdLat data c3", bus.rd_data, 64'h6666);
      nextCycle();
      #2;
      checkOutput("rdLat valid c4", bus.rd_valid, 4'b0010);
      checkOutput("rdLat data c4", bus.rd_data, 64'h7777);
      nextCycle();
      #2;
      checkOutput("rdLat valid c5", bus.rd_valid, 4'b0000);
      nextCycle();

      // 4. Single collision: write wins, read follows and sees the new data.
      setWr(3, 10'h010, 64'hAAAA);
      setRd(1, 10'h010);
      applyStimulus(4'b1000, 4'b0010);
      #2;
      checkOutput("coll wr_gnt", bus.wr_gnt, 4'b1000);
      checkOutput("coll rd_gnt", bus.rd_gnt, 4'b0000);
      checkOutput("coll b_en", bEn, 1'b0);
      nextCycle();
      applyStimulus(4'b0000, 4'b0010);
      #2;
      checkOutput("coll retry rd_gnt", bus.rd_gnt, 4'b0010);
      nextCycle();
      applyStimulus('0, '0);
      nextCycle();
      #2;
      checkOutput("coll valid", bus.rd_valid, 4'b0010);
      checkOutput("coll data", bus.rd_data, 64'hAAAA);
      nextCycle();

      // 5. Repeated collision: second hit holds the write instead.
      setRd(0, 10'h020);
      setWr(1, 10'h020, 64'h1111);
      setWr(2, 10'h020, 64'h2222);
      applyStimulus(4'b0110, 4'b0001);
      #2;
      checkOutput("rep c0 wr_gnt", bus.wr_gnt, 4'b0010);
      checkOutput("rep c0 rd_gnt", bus.rd_gnt, 4'b0000);
      nextCycle();
      applyStimulus(4'b0100, 4'b0001);
      #2;
      checkOutput("rep c1 rd_gnt", bus.rd_gnt, 4'b0001);
      checkOutput("rep c1 wr_gnt", bus.wr_gnt, 4'b0000);
      checkOutput("rep c1 a_en", aEn, 1'b0);
      nextCycle();
      applyStimulus(4'b0100, 4'b0000);
      #2;
      checkOutput("rep c2 wr_gnt", bus.wr_gnt, 4'b0100);
      nextCycle();
      applyStimulus('0, '0);
      #2;
      checkOutput("rep valid", bus.rd_valid, 4'b0001);
      checkOutput("rep data", bus.rd_data, 64'h1111);
      nextCycle();

      // 6. Reset one cycle after a read grant drops the in-flight read.
      setRd(3, 10'h007);
      applyStimulus(4'b0000, 4'b1000);
      #2;
      checkOutput("midrst rd_gnt", bus.rd_gnt, 4'b1000);
      nextCycle();
      applyStimulus('0, '0);
      rst_n = 1'b0;
      #2;
      checkOutput("midrst valid in reset", bus.rd_valid, 4'b0000);
      nextCycle();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         checkOutput("midrst valid after release", bus.rd_valid, 4'b0000);
         nextCycle();
      end
      for (int k = 0; k < N; k++) begin
         setRd(k, AW'(10'h030 + k));
         setWr(k, AW'(10'h040 + k), 64'hBEEF_0000 | 64'(k));
      end
      applyStimulus(4'b1010, 4'b1111);
      #2;
      checkOutput("post-reset rd_gnt", bus.rd_gnt, 4'b0001);
      checkOutput("post-reset wr_gnt", bus.wr_gnt, 4'b0010);
      nextCycle();
      applyStimulus('0, '0);
      for (int i = 0; i < LAT + 2; i++) nextCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
